aes_inv_key_expansion: RTL and testbench

//  AES-128 decryption-side key scheduler. It is the reverse-order counterpart of the encrypt KeyExpansion.
//  On iStart it captures the cipher key and runs 10 forward schedule steps to reach round key 10.
//  It then walks the inverse schedule and presents round keys 10,9,...,0, one per iEn strobe, to the AES decrypt core.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_inv_key_expansion.sv | 111 +++++++++++
 tb/tb_aes_inv_key_expansion.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-word typedef, FSM state encoding and the Rcon table
// used by both the encrypt and decrypt key schedulers.
package aes_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;

  // Word 0 sits in the most significant 32 bits, matching the FIPS-197 byte order.
  typedef logic [0:3][31:0] aes_key_words_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXPAND  = 2'd1,
    ST_REVERSE = 2'd2
  } aes_inv_ks_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a 256-entry constant lookup.
module aes_sbox (
  input  logic [7:0] iByte,
  output logic [7:0] oByte
);

  // Entry 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign oByte = SBOX[iByte];

endmodule

// File: rtl/aes_sub_word.sv
// RotWord followed by SubWord on one 32-bit word; shared by the encrypt and
// decrypt key schedulers.
module aes_sub_word (
  input  logic [31:0] iWord,
  output logic [31:0] oWord
);

  aes_sbox uSbox0 (.iByte(iWord[23:16]), .oByte(oWord[31:24]));
  aes_sbox uSbox1 (.iByte(iWord[15:8]),  .oByte(oWord[23:16]));
  aes_sbox uSbox2 (.iByte(iWord[7:0]),   .oByte(oWord[15:8]));
  aes_sbox uSbox3 (.iByte(iWord[31:24]), .oByte(oWord[7:0]));

endmodule

// File: rtl/aes_inv_key_expansion.sv
// AES-128 decrypt key scheduler: expands forward to round key 10, then steps the
// inverse schedule down to round key 0, one key per iEn strobe.
module aes_inv_key_expansion
  import aes_pkg::*;
#(
  parameter int KEY_W      = AES_KEY_W,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iStart,
  input  logic [KEY_W-1:0] iAesKey,
  input  logic             iEn,
  output logic [KEY_W-1:0] oAesKey,
  output logic [3:0]       oRoundIdx,
  output logic             oKeyValid,
  output logic             oBusy
);

  // Handshake: iStart is a one-cycle request honoured only in IDLE. In REVERSE
  // the key on oAesKey is valid while oKeyValid=1 and is consumed on each cycle
  // with iEn=1; iEn=0 holds it indefinitely.

  aes_inv_ks_state_e stateQ, stateD;
  aes_key_words_t    keyQ, keyD;
  logic [3:0]        cntQ, cntD;

  aes_key_words_t fwdKey, invKey;
  logic [31:0]    invW3, subIn, subOut, rcWord;
  logic [3:0]     rconIdx;

  // One S-box bank: w3 feeds it when expanding, the recovered w3' when reversing.
  assign invW3   = keyQ[3] ^ keyQ[2];
  assign subIn   = (stateQ == ST_REVERSE) ? invW3 : keyQ[3];
  assign rconIdx = (stateQ == ST_REVERSE) ? (cntQ - 4'd1) : cntQ;
  assign rcWord  = {rcon(rconIdx), 24'h0};

  aes_sub_word uSubWord (.iWord(subIn), .oWord(subOut));

  always_comb begin
    fwdKey[0] = keyQ[0] ^ subOut ^ rcWord;
    fwdKey[1] = keyQ[1] ^ fwdKey[0];
    fwdKey[2] = keyQ[2] ^ fwdKey[1];
    fwdKey[3] = keyQ[3] ^ fwdKey[2];

    invKey[3] = invW3;
    invKey[2] = keyQ[2] ^ keyQ[1];
    invKey[1] = keyQ[1] ^ keyQ[0];
    invKey[0] = keyQ[0] ^ subOut ^ rcWord;
  end

  always_comb begin
    stateD = stateQ;
    keyD   = keyQ;
    cntD   = cntQ;
    case (stateQ)
      ST_IDLE: begin
        if (iStart) begin
          keyD   = aes_key_words_t'(iAesKey);
          cntD   = 4'd0;
          stateD = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        keyD = fwdKey;
        if (cntQ == 4'(NUM_ROUNDS - 1)) begin
          cntD   = 4'(NUM_ROUNDS);
          stateD = ST_REVERSE;
        end else begin
          cntD = cntQ + 4'd1;
        end
      end
      ST_REVERSE: begin
        if (iEn) begin
          if (cntQ != 4'd0) begin
            keyD = invKey;
            cntD = cntQ - 4'd1;
          end else begin
            keyD   = '0;
            cntD   = 4'd0;
            stateD = ST_IDLE;
          end
        end
      end
      default: begin
        keyD   = '0;
        cntD   = 4'd0;
        stateD = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      stateQ <= ST_IDLE;
      keyQ   <= '0;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      keyQ   <= keyD;
      cntQ   <= cntD;
    end
  end

  // Outputs are gated so no intermediate expansion key is ever visible.
  assign oKeyValid = (stateQ == ST_REVERSE);
  assign oBusy     = (stateQ == ST_EXPAND);
  assign oAesKey   = oKeyValid ? KEY_W'(keyQ) : '0;
  assign oRoundIdx = oKeyValid ? cntQ : 4'd0;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Directed bench for the AES-128 decrypt key scheduler using FIPS-197 round keys.
module tb_aes_inv_key_expansion;

  logic         iClk = 1'b0;
  logic         iRsn;
  logic         iStart;
  logic         iEn;
  logic [127:0] iAesKey;
  logic [127:0] oAesKey;
  logic [3:0]   oRoundIdx;
  logic         oKeyValid;
  logic         oBusy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] expR10;
  } vec_t;

  logic [127:0] rk [0:10];
  vec_t         vecs [0:1];

  aes_inv_key_expansion dut (
    .iClk      (iClk),
    .iRsn      (iRsn),
    .iStart    (iStart),
    .iAesKey   (iAesKey),
    .iEn       (iEn),
    .oAesKey   (oAesKey),
    .oRoundIdx (oRoundIdx),
    .oKeyValid (oKeyValid),
    .oBusy     (oBusy)
  );

  // clock / reset
  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_key(input logic [127:0] k);
    iAesKey = k;
    iStart  = 1'b1;
    tick();
    iStart  = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (oKeyValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_valid_timeout", 128'(ok), 128'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 128'(oKeyValid), 128'd0);
    check({tag, "_busy"},  128'(oBusy),     128'd0);
    check({tag, "_key"},   oAesKey,         128'd0);
    check({tag, "_idx"},   128'(oRoundIdx), 128'd0);
  endtask

  task automatic async_reset(input string tag);
    iRsn = 1'b0;
    #1;
    check_zero_outputs(tag);
    @(negedge iClk);
    iRsn = 1'b1;
    tick();
  endtask

  initial begin
    int  e;
    bit  done;
    bit  en;

    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{key: rk[0], expR10: rk[10]};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                expR10: 128'h13111d7fe3944a17f307a78b4d2b30c5};

    iRsn = 1'b0; iStart = 1'b0; iEn = 1'b0; iAesKey = '0;
    repeat (2) @(posedge iClk);
    #1;
    check_zero_outputs("reset");
    @(negedge iClk);
    iRsn = 1'b1;
    tick();

    // forward expansion latency
    start_key(rk[0]);
    check("t1_busy_after_start", 128'(oBusy), 128'd1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t1_valid_early", 128'(oKeyValid), 128'd0);
    end
    tick();
    check("t1_valid_at_10", 128'(oKeyValid), 128'd1);
    check("t1_busy_at_10",  128'(oBusy),     128'd0);
    check("t1_idx10",       128'(oRoundIdx), 128'd10);
    check("t1_key10",       oAesKey,         rk[10]);

    // reverse walk with iEn held high, then back-to-back restart
    iEn = 1'b1;
    for (int r = 9; r >= 0; r--) begin
      tick();
      check("t2_idx", 128'(oRoundIdx), 128'(r));
      check("t2_key", oAesKey,         rk[r]);
    end
    tick();
    check("t2_valid_drop", 128'(oKeyValid), 128'd0);
    check("t2_key_drop",   oAesKey,         128'd0);
    iEn = 1'b0;
    start_key(rk[0]);
    check("t6_busy_b2b", 128'(oBusy), 128'd1);

    // random stall against the round-key table
    wait_valid(20);
    check("t3_key10", oAesKey, rk[10]);
    e = 10;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      en  = 1'($urandom_range(0, 1));
      iEn = en;
      tick();
      if (en && e == 0) begin
        done = 1'b1;
        check("t3_valid_drop", 128'(oKeyValid), 128'd0);
      end else begin
        if (en) e--;
        check("t3_idx", 128'(oRoundIdx), 128'(e));
        check("t3_key", oAesKey,         rk[e]);
      end
    end
    iEn = 1'b0;
    if (!done) check("t3_walk_timeout", 128'(done), 128'd1);

    // ignored inputs: iEn in IDLE, iStart during EXPAND and REVERSE
    iEn = 1'b1;
    repeat (3) begin
      tick();
      check_zero_outputs("t4_idle_en");
    end
    iEn = 1'b0;
    start_key(rk[0]);
    repeat (3) tick();
    start_key({128{1'b1}});
    wait_valid(20);
    check("t4_key10_after_restart_try", oAesKey, rk[10]);
    iStart = 1'b1;
    tick();
    check("t4_hold_idx", 128'(oRoundIdx), 128'd10);
    check("t4_hold_key", oAesKey,         rk[10]);
    iEn = 1'b1;
    tick();
    iStart = 1'b0;
    check("t4_start_en_idx", 128'(oRoundIdx), 128'd9);
    check("t4_start_en_key", oAesKey,         rk[9]);
    repeat (9) tick();
    check("t4_idx0", 128'(oRoundIdx), 128'd0);
    check("t4_key0", oAesKey,         rk[0]);
    tick();
    iEn = 1'b0;
    check("t4_valid_drop", 128'(oKeyValid), 128'd0);

    // asynchronous reset mid-EXPAND and at idx 4
    start_key(rk[0]);
    repeat (5) tick();
    check("t5_busy_mid", 128'(oBusy), 128'd1);
    async_reset("t5_rst_expand");
    start_key(rk[0]);
    wait_valid(20);
    iEn = 1'b1;
    repeat (6) tick();
    iEn = 1'b0;
    check("t5_idx4", 128'(oRoundIdx), 128'd4);
    check("t5_key4", oAesKey,         rk[4]);
    async_reset("t5_rst_reverse");

    // table-driven full expand/reverse per key
    for (int v = 0; v < 2; v++) begin
      start_key(vecs[v].key);
      wait_valid(20);
      check("tv_idx10", 128'(oRoundIdx), 128'd10);
      check("tv_key10", oAesKey,         vecs[v].expR10);
      iEn = 1'b1;
      repeat (10) tick();
      check("tv_idx0", 128'(oRoundIdx), 128'd0);
      check("tv_key0", oAesKey,         vecs[v].key);
      tick();
      iEn = 1'b0;
      check("tv_valid_drop", 128'(oKeyValid), 128'd0);
      tick();
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
